fifo_rd_stream: RTL and testbench

- Read-side consumer of the async FIFO, clocked in the read domain.
- Pops words from the FIFO read port (rempty/rinc/rdata) into a 2-entry output buffer.
- Presents the words as a valid/ready stream, marking packet boundaries with m_last every PKT_LEN beats.
- Provides a flush that discards buffered and queued words and counts them.

---
 rtl/fifo_rd_stream.sv | 92 +++++++++
 tb/tb_fifo_rd_stream.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-domain FIFO consumer: pops into a 2-entry buffer, emits a valid/ready stream with m_last framing.
// Latency: one rclk from FIFO pop to m_valid; sustains one word per cycle with m_ready held high.
// Backpressure: m_ready low stalls output; pops stop when both entries are full (no m_ready->rinc path).
module fifo_rd_stream #(
    parameter int DSIZE   = 8,
    parameter int PKT_LEN = 16,
    parameter int CNTW    = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    output logic [CNTW-1:0]  drop_cnt
);

    localparam int              BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0]   LAST_BEAT = BW'(PKT_LEN - 1);
    localparam logic [CNTW-1:0] DROP_MAX  = '1;

    logic [1:0]       cnt_q, cnt_d;
    logic [DSIZE-1:0] e0_q, e0_d;
    logic [DSIZE-1:0] e1_q, e1_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [CNTW-1:0]  drop_q, drop_d;
    logic             push;
    logic             fire;
    logic [CNTW+1:0]  drop_sum;

    assign m_valid  = (cnt_q != 2'd0) & ~flush;
    assign m_data   = e0_q;
    assign m_last   = (beat_q == LAST_BEAT);
    assign fire     = m_valid & m_ready;
    // Pop decision uses occupancy only, so m_ready never reaches rinc combinationally.
    assign rinc     = rrst_n & ~rempty & (flush | (cnt_q != 2'd2));
    assign push     = rinc & ~rempty;
    assign drop_cnt = drop_q;
    assign drop_sum = {2'b00, drop_q} + {{CNTW{1'b0}}, cnt_q} + {{(CNTW+1){1'b0}}, push};

    always_comb begin
        cnt_d  = cnt_q;
        e0_d   = e0_q;
        e1_d   = e1_q;
        beat_d = beat_q;
        drop_d = drop_q;
        if (flush) begin
            // Buffered words plus the word popped this cycle are all discarded.
            cnt_d  = 2'd0;
            beat_d = '0;
            drop_d = (drop_sum > {2'b00, DROP_MAX}) ? DROP_MAX : drop_sum[CNTW-1:0];
        end else begin
            if (fire) begin
                beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
            end
            case ({push, fire})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = rdata;
                    else               e1_d = rdata;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: e0_d = rdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_q  <= 2'd0;
            e0_q   <= '0;
            e1_q   <= '0;
            beat_q <= '0;
            drop_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            e0_q   <= e0_d;
            e1_q   <= e1_d;
            beat_q <= beat_d;
            drop_q <= drop_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: FIFO head model feeds the stream block, monitor pops expected words on every fire.
module tb_fifo_rd_stream;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       rempty = 1'b1;
    logic [7:0] rdata = 8'h00;
    logic       rinc;
    logic       flush;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [3:0] drop_cnt;

    logic       rempty1 = 1'b0;
    logic [7:0] rdata1 = 8'h5A;
    logic       flush1 = 1'b0;
    logic       m_ready1 = 1'b1;
    logic       rinc1, mv1, ml1;
    logic [7:0] md1;
    logic [3:0] dc1;

    int   tests = 0;
    int   fails = 0;
    int   fire_cnt = 0;
    int   pop_cnt = 0;
    int   exp_beat = 0;
    bit   pop_now;
    bit   stall_v = 0;
    logic [8:0] stall_val;
    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];

    bit         t1_rinc[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit         t1_vld[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] t1_dat[5]  = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    bit         t3_rinc[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    fifo_rd_stream #(.DSIZE(8), .PKT_LEN(16), .CNTW(4)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .drop_cnt(drop_cnt)
    );

    fifo_rd_stream #(.DSIZE(8), .PKT_LEN(1), .CNTW(4)) dut1 (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty1), .rdata(rdata1), .rinc(rinc1),
        .flush(flush1), .m_valid(mv1), .m_ready(m_ready1), .m_data(md1),
        .m_last(ml1), .drop_cnt(dc1)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic refresh();
        rempty = (fifo_q.size() == 0);
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic add_exp(input logic [7:0] d);
        exp_t e;
        e.d    = d;
        e.last = (exp_beat == 15);
        exp_q.push_back(e);
        exp_beat = (exp_beat == 15) ? 0 : exp_beat + 1;
    endtask

    task automatic add_word(input logic [7:0] d, input bit chk_it);
        fifo_q.push_back(d);
        if (chk_it) add_exp(d);
        refresh();
    endtask

    task automatic to_neg();
        @(negedge rclk);
    endtask

    task automatic to_drv();
        @(posedge rclk);
        #1;
    endtask

    task automatic drain(input int maxc, input string nm);
        for (int i = 0; i < maxc && exp_q.size() != 0; i++) to_drv();
        chk(nm, exp_q.size(), 0);
    endtask

    // FIFO head model: pop decided on pre-edge values, head refreshed just after the edge.
    always @(posedge rclk) begin
        pop_now = rinc && !rempty;
        #1;
        if (pop_now) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        refresh();
    end

    always @(negedge rclk) begin
        if (!rrst_n) begin
            stall_v = 0;
        end else begin
            if (stall_v && m_valid) chk("hold", {m_last, m_data}, stall_val);
            if (m_valid && m_ready) begin
                fire_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat at %0t", m_data, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("data", m_data, e.d);
                    chk("last", m_last, e.last);
                end
            end
            stall_v   = m_valid && !m_ready;
            stall_val = {m_last, m_data};
            if (mv1) chk("pkt1_last", ml1, 1);
        end
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int p0;
        int f0;
        rrst_n  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        add_word(8'h11, 1);
        add_word(8'h22, 1);
        add_word(8'h33, 1);

        // Reset state
        to_neg();
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_rinc", rinc, 0);
        chk("rst_pkt1_last", ml1, 1);
        to_drv();
        rrst_n = 1'b1;

        // First-word latency and back-to-back pops
        for (int i = 0; i < 5; i++) begin
            to_neg();
            chk("t1_rinc", rinc, t1_rinc[i]);
            chk("t1_valid", m_valid, t1_vld[i]);
            if (t1_vld[i]) chk("t1_data", m_data, t1_dat[i]);
            to_drv();
        end

        // 40-word continuous stream, then 8 more to land on the next m_last
        rrst_n = 1'b0;
        #2;
        rrst_n = 1'b1;
        exp_beat = 0;
        f0 = fire_cnt;
        for (int i = 0; i < 40; i++) add_word(8'h40 + 8'(i), 1);
        repeat (41) to_drv();
        chk("t2_fires", fire_cnt - f0, 40);
        chk("t2_left", exp_q.size(), 0);
        for (int i = 0; i < 8; i++) add_word(8'h80 + 8'(i), 1);
        drain(20, "t2_drain");

        // Backpressure: two pops then stall
        m_ready = 1'b0;
        p0 = pop_cnt;
        for (int i = 0; i < 4; i++) add_word(8'h90 + 8'(i), 1);
        for (int i = 0; i < 5; i++) begin
            to_neg();
            chk("t3_rinc", rinc, t3_rinc[i]);
            if (i > 0) chk("t3_head", m_data, 8'h90);
            to_drv();
        end
        chk("t3_pops", pop_cnt - p0, 2);
        m_ready = 1'b1;
        drain(20, "t3_drain");

        // Random ready against random fill of 1000 incrementing words
        sent = 0;
        for (int c = 0; c < 20000 && (sent < 1000 || exp_q.size() != 0); c++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (sent < 1000 && $urandom_range(0, 1) == 1) begin
                int n;
                n = $urandom_range(1, 3);
                for (int k = 0; k < n && sent < 1000; k++) begin
                    add_word(sent[7:0], 1);
                    sent++;
                end
            end
            to_drv();
        end
        chk("t4_sent", sent, 1000);
        chk("t4_drain", exp_q.size(), 0);
        m_ready = 1'b1;
        to_drv();

        // Flush with full buffer and 3 queued words
        m_ready = 1'b0;
        add_word(8'hA0, 0);
        add_word(8'hA1, 0);
        repeat (3) to_drv();
        for (int i = 0; i < 3; i++) add_word(8'hA2 + 8'(i), 0);
        flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            to_neg();
            chk("t5_valid", m_valid, 0);
            to_drv();
        end
        flush = 1'b0;
        chk("t5_drop", drop_cnt, 5);
        exp_beat = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) add_word(8'hB0 + 8'(i), 1);
        drain(40, "t5_drain");

        // Saturation of drop_cnt
        flush = 1'b1;
        for (int i = 0; i < 9; i++) add_word(8'hE0 + 8'(i), 0);
        repeat (10) to_drv();
        flush = 1'b0;
        chk("t6_drop14", drop_cnt, 14);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) add_word(8'hF0 + 8'(i), 0);
        repeat (3) to_drv();
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            to_drv();
            chk("t6_drop_sat", drop_cnt, 15);
        end
        flush = 1'b0;

        // Asynchronous reset mid-packet
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) add_word(8'hC0 + 8'(i), 1);
        drain(20, "t7_pre");
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) add_word(8'hD0 + 8'(i), 0);
        repeat (3) to_drv();
        #2;
        rrst_n = 1'b0;
        #1;
        chk("t7_valid", m_valid, 0);
        chk("t7_data", m_data, 0);
        chk("t7_last", m_last, 0);
        chk("t7_drop", drop_cnt, 0);
        chk("t7_rinc", rinc, 0);
        to_neg();
        chk("t7_rinc_hold", rinc, 0);
        to_drv();
        rrst_n = 1'b1;
        exp_beat = 0;
        add_exp(8'hD2);
        m_ready = 1'b1;
        drain(20, "t7_drain");
        chk("t7_drop_after", drop_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
